fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch unit, the producer end of the decodec instruction interface. Owns the 10-bit program counter, requests 16-bit words from program memory over a req/ack handshake, and presents each word to the decoder with a valid/ready handshake. Consumes the decoder's jmpEnable/jmpDir and branchEnable/branchDir to redirect the PC.

Parameters:
RESET_ADDR, 10'd0, PC value loaded on reset (first instruction fetched).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
memReq  out  1  program-memory read request
memAddr  out  10  read address, equals PC while memReq=1
memAck  in  1  memory has data; memData valid this cycle
memData  in  16  instruction word from program memory
instr  out  16  instruction presented to decoder (decodec in)
instrAddr  out  10  address of presented instruction
instrValid  out  1  instr holds a fetched, unconsumed word
instrReady  in  1  core consumes instr this cycle
jmpEnable  in  1  from decoder; absolute jump
jmpDir  in  10  jump target
branchEnable  in  1  from decoder; taken branch
branchDir  in  6  signed branch offset, two's complement

Behaviour:
- Reset is synchronous: the cycle after a clock edge with reset=1 is in IDLE, pc=RESET_ADDR, instr=16'h0000, instrAddr=0, instrValid=0, memReq=0. memAddr = pc.
- States: IDLE, REQ, HOLD. Encoding is in the package.
- IDLE: memReq=0, instrValid=0. Always -> REQ on the next cycle.
- REQ: memReq=1, memAddr=pc. Wait in REQ until memAck=1. On an ack cycle: instr<=memData, instrAddr<=pc, -> HOLD. memAck may assert in the first REQ cycle (zero wait states) or any number of cycles later. memAddr must stay stable while in REQ.
- HOLD: instrValid=1, memReq=0; instr and instrAddr stay stable. Remain in HOLD while instrReady=0. On instrReady=1 (consume), update the PC and go -> REQ:
  - jmpEnable=1: pc <= jmpDir.
  - else branchEnable=1: pc <= instrAddr + sign_extend(branchDir), modulo 1024. Offset is relative to the branch instruction's own address.
  - else: pc <= instrAddr + 1, wrapping 1023 -> 0.
- jmpEnable and branchEnable both 1: the jump wins.
- Redirect inputs are sampled only on a consume cycle in HOLD; they are ignored in all other states/cycles.
- memAck outside REQ is ignored; memData is captured only on REQ && memAck.
- instrReady outside HOLD is ignored.
- Throughput: best case one instruction per 2 cycles (REQ with immediate ack, HOLD with immediate ready). No prefetch, at most one outstanding request.
- Latency: first memReq is asserted in the 2nd cycle after reset deasserts (IDLE, then REQ).
- Reset mid-operation (REQ or HOLD): abandon the request/instruction, return to IDLE with reset values, restart at RESET_ADDR. A late memAck after reset is ignored because the unit is in IDLE.

Decomposition:
- Shared package (alongside def.v opcode defines): state encoding FETCH_IDLE/FETCH_REQ/FETCH_HOLD, PC_WIDTH=10, INSTR_WIDTH=16, BRANCH_WIDTH=6.
- One natural sub-module: pc_next, a combinational next-PC selector (jump / sign-extended branch add / increment with wrap). The FSM and registers stay in fetch_unit.

Test Plan:
- Reset then sequential fetch, memAck immediate, instrReady=1: memAddr sequence 0,1,2,3. instr matches memory, instrAddr matches address, one instruction per 2 cycles.
- Wait states: memAck delayed 3 cycles at addr 5. memReq/memAddr=5 held 4 cycles, instrValid rises the cycle after the ack. Backpressure instrReady=0 for 4 cycles: instr stable, no memReq.
- Jump at instrAddr 12 with jmpEnable=1, jmpDir=10'd700: next memAddr=700. With jmpEnable and branchEnable both 1 (branchDir=6'd3): next memAddr=700.
- Branch at instrAddr 20: branchDir=6'b111100 (-4) -> next 16; branchDir=6'd31 -> next 51. At instrAddr 2 with branchDir=-4 -> next 1022 (wrap).
- Increment wrap: consume instr at 1023 with no redirect -> next memAddr=0. Redirect asserted while instrReady=0 has no effect.
- Reset asserted in REQ (addr 40, ack pending) and in HOLD: IDLE next cycle, instrValid=0, memReq=0, then REQ at RESET_ADDR. A stray memAck during IDLE is not captured.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths and FSM state encoding.
package fetch_unit_pkg;

    localparam int PC_WIDTH     = 10;
    localparam int INSTR_WIDTH  = 16;
    localparam int BRANCH_WIDTH = 6;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selector: absolute jump, PC-relative branch, or increment.
import fetch_unit_pkg::*;

module fetch_unit_pc_next (
    input  logic [PC_WIDTH-1:0]     i_instrAddr,
    input  logic                    i_jmpEnable,
    input  logic [PC_WIDTH-1:0]     i_jmpDir,
    input  logic                    i_branchEnable,
    input  logic [BRANCH_WIDTH-1:0] i_branchDir,
    output logic [PC_WIDTH-1:0]     o_pcNext
);

    logic [PC_WIDTH-1:0] w_branchOff;

    // Branch offset is relative to the branch's own address; sums wrap mod 1024.
    assign w_branchOff = {{(PC_WIDTH-BRANCH_WIDTH){i_branchDir[BRANCH_WIDTH-1]}}, i_branchDir};

    always_comb begin
        o_pcNext = i_instrAddr + 10'd1;
        if (i_jmpEnable)
            o_pcNext = i_jmpDir;
        else if (i_branchEnable)
            o_pcNext = i_instrAddr + w_branchOff;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, reads program memory via req/ack and
// hands each word to the decoder via valid/ready, redirecting on jump/branch.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter logic [PC_WIDTH-1:0] RESET_ADDR = 10'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    memReq,
    output logic [PC_WIDTH-1:0]     memAddr,
    input  logic                    memAck,
    input  logic [INSTR_WIDTH-1:0]  memData,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [PC_WIDTH-1:0]     instrAddr,
    output logic                    instrValid,
    input  logic                    instrReady,
    input  logic                    jmpEnable,
    input  logic [PC_WIDTH-1:0]     jmpDir,
    input  logic                    branchEnable,
    input  logic [BRANCH_WIDTH-1:0] branchDir
);

    fetch_state_t           r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_instrAddr;
    logic                   r_memReq;
    logic                   r_instrValid;
    logic [PC_WIDTH-1:0]    w_pcNext;

    fetch_unit_pc_next u_pc_next (
        .i_instrAddr    (r_instrAddr),
        .i_jmpEnable    (jmpEnable),
        .i_jmpDir       (jmpDir),
        .i_branchEnable (branchEnable),
        .i_branchDir    (branchDir),
        .o_pcNext       (w_pcNext)
    );

    // memReq/instrValid are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_ADDR;
            r_instr      <= '0;
            r_instrAddr  <= '0;
            r_memReq     <= 1'b0;
            r_instrValid <= 1'b0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    r_state  <= FETCH_REQ;
                    r_memReq <= 1'b1;
                end
                FETCH_REQ: begin
                    if (memAck) begin
                        r_instr      <= memData;
                        r_instrAddr  <= r_pc;
                        r_state      <= FETCH_HOLD;
                        r_memReq     <= 1'b0;
                        r_instrValid <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (instrReady) begin
                        r_pc         <= w_pcNext;
                        r_state      <= FETCH_REQ;
                        r_memReq     <= 1'b1;
                        r_instrValid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= FETCH_IDLE;
                    r_memReq     <= 1'b0;
                    r_instrValid <= 1'b0;
                end
            endcase
        end
    end

    assign memReq     = r_memReq;
    assign memAddr    = r_pc;
    assign instr      = r_instr;
    assign instrAddr  = r_instrAddr;
    assign instrValid = r_instrValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, wait states, backpressure,
// jump/branch redirects, PC wrap and mid-operation reset.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memReq;
    logic [9:0]  memAddr;
    logic        memAck;
    logic [15:0] memData;
    logic [15:0] instr;
    logic [9:0]  instrAddr;
    logic        instrValid;
    logic        instrReady;
    logic        jmpEnable;
    logic [9:0]  jmpDir;
    logic        branchEnable;
    logic [5:0]  branchDir;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_ADDR(10'd0)) dut (
        .clk          (clk),
        .reset        (reset),
        .memReq       (memReq),
        .memAddr      (memAddr),
        .memAck       (memAck),
        .memData      (memData),
        .instr        (instr),
        .instrAddr    (instrAddr),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .jmpEnable    (jmpEnable),
        .jmpDir       (jmpDir),
        .branchEnable (branchEnable),
        .branchDir    (branchDir)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_word(input logic [9:0] a);
        return 16'h5A00 ^ {6'd0, a} ^ {a[5:0], 10'd0};
    endfunction

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From REQ: ack the current address, then consume with the given redirect.
    task automatic consume(input logic je, input logic [9:0] jd, input logic be, input logic [5:0] bd);
        memAck  = 1'b1;
        memData = mem_word(memAddr);
        tick();
        memAck       = 1'b0;
        instrReady   = 1'b1;
        jmpEnable    = je;
        jmpDir       = jd;
        branchEnable = be;
        branchDir    = bd;
        tick();
        instrReady   = 1'b0;
        jmpEnable    = 1'b0;
        branchEnable = 1'b0;
    endtask

    task automatic goto_addr(input logic [9:0] a);
        consume(1'b1, a, 1'b0, 6'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq: got %b want 0", memReq); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_instrValid: got %b want 0", instrValid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (instrAddr !== 10'd0) begin errors++; $display("FAIL reset_instrAddr: got %0d want 0", instrAddr); end
        checks++; if (memAddr !== 10'd0) begin errors++; $display("FAIL reset_memAddr: got %0d want 0", memAddr); end
        reset = 1'b0;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL idle_cycle_memReq: got %b want 0", memReq); end
        tick();
        checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL first_req_latency: got %b want 1", memReq); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            checks++; if (memReq !== 1'b1 || memAddr !== 10'(k)) begin errors++; $display("FAIL seq_req: got req=%b addr=%0d want req=1 addr=%0d", memReq, memAddr, k); end
            memAck  = 1'b1;
            memData = mem_word(10'(k));
            tick();
            memAck     = 1'b0;
            checks++; if (instrValid !== 1'b1 || instr !== mem_word(10'(k)) || instrAddr !== 10'(k)) begin errors++; $display("FAIL seq_hold: got v=%b instr=%h addr=%0d want v=1 instr=%h addr=%0d", instrValid, instr, instrAddr, mem_word(10'(k)), k); end
            checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL seq_hold_memReq: got %b want 0", memReq); end
            instrReady = 1'b1;
            tick();
            instrReady = 1'b0;
        end
        checks++; if (memAddr !== 10'd4 || memReq !== 1'b1) begin errors++; $display("FAIL seq_next: got req=%b addr=%0d want req=1 addr=4", memReq, memAddr); end
    endtask

    task automatic test_wait_states();
        consume(1'b0, 10'd0, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (memReq !== 1'b1 || memAddr !== 10'd5 || instrValid !== 1'b0) begin errors++; $display("FAIL wait_req: got req=%b addr=%0d v=%b want req=1 addr=5 v=0", memReq, memAddr, instrValid); end
            tick();
        end
        checks++; if (memReq !== 1'b1 || memAddr !== 10'd5) begin errors++; $display("FAIL wait_req_last: got req=%b addr=%0d want req=1 addr=5", memReq, memAddr); end
        memAck  = 1'b1;
        memData = mem_word(10'd5);
        tick();
        memAck = 1'b0;
        checks++; if (instrValid !== 1'b1 || instr !== mem_word(10'd5) || instrAddr !== 10'd5) begin errors++; $display("FAIL wait_capture: got v=%b instr=%h addr=%0d want v=1 instr=%h addr=5", instrValid, instr, instrAddr, mem_word(10'd5)); end
        // Redirect and a stray ack during backpressure must have no effect.
        jmpEnable = 1'b1;
        jmpDir    = 10'd300;
        memAck    = 1'b1;
        memData   = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (instrValid !== 1'b1 || memReq !== 1'b0 || instr !== mem_word(10'd5) || instrAddr !== 10'd5) begin errors++; $display("FAIL backpressure: got v=%b req=%b instr=%h addr=%0d", instrValid, memReq, instr, instrAddr); end
        end
        memAck    = 1'b0;
        jmpEnable = 1'b0;
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        checks++; if (memAddr !== 10'd6 || memReq !== 1'b1) begin errors++; $display("FAIL after_backpressure: got req=%b addr=%0d want req=1 addr=6", memReq, memAddr); end
    endtask

    task automatic test_jump();
        goto_addr(10'd12);
        consume(1'b1, 10'd700, 1'b0, 6'd0);
        checks++; if (memAddr !== 10'd700) begin errors++; $display("FAIL jump_target: got %0d want 700", memAddr); end
        goto_addr(10'd12);
        consume(1'b1, 10'd700, 1'b1, 6'd3);
        checks++; if (memAddr !== 10'd700) begin errors++; $display("FAIL jump_priority: got %0d want 700", memAddr); end
    endtask

    task automatic test_branch();
        goto_addr(10'd20);
        consume(1'b0, 10'd0, 1'b1, 6'b111100);
        checks++; if (memAddr !== 10'd16) begin errors++; $display("FAIL branch_back: got %0d want 16", memAddr); end
        goto_addr(10'd20);
        consume(1'b0, 10'd0, 1'b1, 6'd31);
        checks++; if (memAddr !== 10'd51) begin errors++; $display("FAIL branch_fwd: got %0d want 51", memAddr); end
        goto_addr(10'd2);
        consume(1'b0, 10'd0, 1'b1, 6'b111100);
        checks++; if (memAddr !== 10'd1022) begin errors++; $display("FAIL branch_wrap: got %0d want 1022", memAddr); end
    endtask

    task automatic test_wrap();
        goto_addr(10'd1023);
        consume(1'b0, 10'd0, 1'b0, 6'd0);
        checks++; if (memAddr !== 10'd0) begin errors++; $display("FAIL incr_wrap: got %0d want 0", memAddr); end
    endtask

    task automatic test_reset_mid();
        goto_addr(10'd40);
        checks++; if (memReq !== 1'b1 || memAddr !== 10'd40) begin errors++; $display("FAIL pre_reset_req: got req=%b addr=%0d want req=1 addr=40", memReq, memAddr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (memReq !== 1'b0 || instrValid !== 1'b0 || memAddr !== 10'd0) begin errors++; $display("FAIL reset_in_req: got req=%b v=%b addr=%0d want 0 0 0", memReq, instrValid, memAddr); end
        memAck  = 1'b1;
        memData = 16'hBEEF;
        tick();
        memAck = 1'b0;
        checks++; if (memReq !== 1'b1 || memAddr !== 10'd0 || instrValid !== 1'b0 || instr !== 16'h0000) begin errors++; $display("FAIL stray_ack_idle: got req=%b addr=%0d v=%b instr=%h want 1 0 0 0000", memReq, memAddr, instrValid, instr); end
        goto_addr(10'd77);
        memAck  = 1'b1;
        memData = mem_word(10'd77);
        tick();
        memAck = 1'b0;
        checks++; if (instrValid !== 1'b1 || instrAddr !== 10'd77) begin errors++; $display("FAIL pre_reset_hold: got v=%b addr=%0d want v=1 addr=77", instrValid, instrAddr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (instrValid !== 1'b0 || memReq !== 1'b0 || instr !== 16'h0000 || instrAddr !== 10'd0) begin errors++; $display("FAIL reset_in_hold: got v=%b req=%b instr=%h addr=%0d want 0 0 0000 0", instrValid, memReq, instr, instrAddr); end
        tick();
        checks++; if (memReq !== 1'b1 || memAddr !== 10'd0) begin errors++; $display("FAIL restart_req: got req=%b addr=%0d want req=1 addr=0", memReq, memAddr); end
    endtask

    initial begin
        reset        = 1'b1;
        memAck       = 1'b0;
        memData      = 16'h0000;
        instrReady   = 1'b0;
        jmpEnable    = 1'b0;
        jmpDir       = 10'd0;
        branchEnable = 1'b0;
        branchDir    = 6'd0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_jump();
        test_branch();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
